// File: rtl/shiftmix_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : shiftmix_stage_if
// Brief    : Upstream/downstream handshake and data bundle for shiftmix_stage.
// Revision : 1.0 - initial release
// ============================================================================
interface shiftmix_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         final_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport slave (
        input  in_valid, state_in, round_key, final_round, out_ready,
        output in_ready, out_valid, state_out
    );

    modport master (
        output in_valid, state_in, round_key, final_round, out_ready,
        input  in_ready, out_valid, state_out
    );
endinterface
`default_nettype wire

// File: rtl/shiftmix_stage.sv
`default_nettype none
// ============================================================================
// Module   : shiftmix_stage
// Brief    : AES round tail: ShiftRows -> MixColumns (bypassed on the final
//            round) -> AddRoundKey, as a two-stage valid/ready pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module shiftmix_stage (
    input  wire logic        clk,
    input  wire logic        rst_n,
    shiftmix_stage_if.slave  bus
);

    localparam logic [7:0] C_POLY_LOW = 8'h1b;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? C_POLY_LOW : 8'h00);
    endfunction

    // Column bytes are row 0 in the MSB through row 3 in the LSB.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    logic [127:0] w_shifted;
    logic [127:0] w_mixed;
    logic [127:0] w_s1_next;
    logic         w_s2_load;
    logic         w_s1_load;

    logic         r_s1_valid;
    logic [127:0] r_s1_data;
    logic [127:0] r_s1_key;
    logic         r_s2_valid;
    logic [127:0] r_s2_data;

    assign w_shifted = shift_rows(bus.state_in);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign w_mixed[127 - 32*gi -: 32] = mix_column(w_shifted[127 - 32*gi -: 32]);
        end
    endgenerate

    assign w_s1_next = bus.final_round ? w_shifted : w_mixed;

    // S1 can only advance when S2 has room, which makes w_s1_load identical to in_ready.
    assign w_s2_load    = !r_s2_valid || bus.out_ready;
    assign w_s1_load    = !r_s1_valid || w_s2_load;
    assign bus.in_ready = !r_s1_valid || !r_s2_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_key   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_data <= w_s1_next;
                    r_s1_key  <= bus.round_key;
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data ^ r_s1_key;
                end
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.state_out = r_s2_data;

endmodule
`default_nettype wire

// File: tb/tb_shiftmix_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftmix_stage
// Brief    : Directed, table-driven self-checking bench for shiftmix_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftmix_stage;

    typedef struct {
        logic [127:0] state;
        logic [127:0] key;
        logic         fin;
        logic [127:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shiftmix_stage_if bus();
    shiftmix_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    vec_t         vecs [7];
    int           errors = 0;
    int           checks = 0;
    logic [127:0] cur_exp = '0;
    logic [127:0] sb [$];
    int           out_count = 0;

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input vec_t x);
        bus.in_valid    = v;
        bus.state_in    = x.state;
        bus.round_key   = x.key;
        bus.final_round = x.fin;
        cur_exp         = x.exp;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Output scoreboard: every accepted block must leave once, in acceptance order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h required none", bus.state_out);
                end else begin
                    check128("sb_order", bus.state_out, sb.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running required finished");
        $fatal(1);
    end

    initial begin
        logic [11:0] ov;
        int          idx;
        int          guard;
        int          cnt;
        logic        fire;

        vecs[0] = '{ {4{32'hdb135345}}, 128'h0, 1'b0, {4{32'h8e4da1bc}} };
        vecs[1] = '{ 128'h000102030405060708090a0b0c0d0e0f, 128'h0, 1'b1,
                     128'h00050a0f04090e03080d02070c01060b };
        vecs[2] = '{ {4{32'h01010101}}, {16{8'hff}}, 1'b0, {16{8'hfe}} };
        vecs[3] = '{ 128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
                     1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049 };
        vecs[4] = '{ {4{32'hf20a225c}}, 128'h0, 1'b0, {4{32'h9fdc589d}} };
        vecs[5] = '{ {4{32'hc6c6c6c6}}, 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                     128'hc6c7c4c5c2c3c0c1cecfcccdcacbc8c9 };
        vecs[6] = '{ {4{32'hdb135345}}, {16{8'hff}}, 1'b1, {4{32'h24ecacba}} };

        bus.in_valid    = 1'b0;
        bus.state_in    = '0;
        bus.round_key   = '0;
        bus.final_round = 1'b0;
        bus.out_ready   = 1'b1;

        #3;
        check_int("reset_out_valid", int'(bus.out_valid), 0);
        check128("reset_state_out", bus.state_out, 128'h0);
        check_int("reset_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // One block at a time: output visible in the second cycle after presentation.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i]);
            @(negedge clk);
            check_int("vec_in_ready", int'(bus.in_ready), 1);
            next_cycle();
            bus.in_valid = 1'b0;
            @(negedge clk);
            check_int("vec_latency_early", int'(bus.out_valid), 0);
            next_cycle();
            @(negedge clk);
            check_int("vec_out_valid", int'(bus.out_valid), 1);
            check128("vec_state_out", bus.state_out, vecs[i].exp);
            next_cycle();
        end

        // Backpressure: two accepted, then held full for five cycles.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, vecs[k]);
            @(negedge clk);
            check_int("bp_accept", int'(bus.in_ready), 1);
            next_cycle();
        end
        drive(1'b1, vecs[2]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_int("bp_in_ready_low", int'(bus.in_ready), 0);
            check_int("bp_out_valid", int'(bus.out_valid), 1);
            check128("bp_state_hold", bus.state_out, vecs[0].exp);
            next_cycle();
        end
        bus.out_ready = 1'b1;
        idx   = 2;
        guard = 0;
        while (idx < 4 && guard < 20) begin
            drive(1'b1, vecs[idx]);
            @(negedge clk);
            fire = bus.in_ready;
            next_cycle();
            if (fire) idx++;
            guard++;
        end
        check_int("bp_all_accepted", idx, 4);
        bus.in_valid = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            next_cycle();
            guard++;
        end
        check_int("bp_drained", sb.size(), 0);

        // Streaming: eight blocks back to back.
        ov = '0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive(1'b1, vecs[c % 7]);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            ov[c] = bus.out_valid;
            if (c < 8) check_int("stream_in_ready", int'(bus.in_ready), 1);
            next_cycle();
        end
        check128("stream_out_valid_pattern", {116'h0, ov}, {116'h0, 12'h3fc});
        check_int("stream_drained", sb.size(), 0);

        // Reset with both stages full discards everything in flight.
        bus.out_ready = 1'b0;
        for (int k = 3; k < 5; k++) begin
            drive(1'b1, vecs[k]);
            next_cycle();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_int("rst_pre_full", int'(bus.in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("rst_out_valid", int'(bus.out_valid), 0);
        check128("rst_state_out", bus.state_out, 128'h0);
        check_int("rst_in_ready", int'(bus.in_ready), 1);
        sb.delete();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
            next_cycle();
        end
        check_int("rst_no_ghost_output", cnt, 0);
        check_int("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
